acc_dump: RTL and testbench
===========================

Name: acc_dump

Overview:
- Parametrised integrate-and-dump accumulator. Next generation of the team's 8-bit running-sum delay/accumulate block.
- Sums a programmable number of valid input samples into a wide accumulator, emits the frame total with a one-cycle valid pulse, then restarts from zero.
- Sits between sample sources and decimating/averaging stages in the datapath.

Parameters:
IN_W, 8, input sample width (unsigned)
ACC_W, 16, accumulator/output width; must be >= IN_W
CNT_W, 8, width of frame-length field; max frame = 2^CNT_W samples

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data carries a sample this cycle
in_data  input  IN_W  unsigned sample, zero-extended to ACC_W
len  input  CNT_W  frame length minus 1; sampled at frame start
clear  input  1  synchronous abort of current frame
acc_q  output  ACC_W  registered partial sum of current frame
out_valid  output  1  one-cycle pulse, frame total on out_data
out_data  output  ACC_W  frame total; held until next pulse
out_ovf  output  1  frame overflowed (SAT_EN only, else 0); qualified by out_valid
busy  output  1  frame in progress (state ACCUM)

Behaviour:
- Reset: rst_n low asynchronously forces acc_q=0, cnt=0, len_q=0, out_valid=0, out_data=0, out_ovf=0, busy=0, state IDLE. Reset mid-frame discards the partial sum.
- States:
  - IDLE (cnt=0, acc_q=0).
  - ACCUM (at least one sample accepted, frame not complete).
- Sample acceptance (in_valid=1, clear=0):
  - In IDLE: len_q<=len. If len=0, dump immediately. Else acc_q<=in_data, cnt<=1, go to ACCUM.
  - In ACCUM: sum=acc_q+in_data. If cnt==len_q, dump. Else acc_q<=sum, cnt<=cnt+1.
  - Dump: out_data<=sum (IDLE with len=0: sum=in_data), out_valid<=1 next cycle, acc_q<=0, cnt<=0, go to IDLE.
- len changes during ACCUM are ignored until the next frame start.
- Latency: out_valid asserts exactly 1 cycle after the edge that accepts the last sample of the frame. Back-to-back frames are supported with no bubble; the first sample of the next frame may arrive in the cycle after the last sample.
- in_valid=0: no state change. out_valid deasserts after its single cycle.
- clear=1: acc_q<=0, cnt<=0, go to IDLE, no out_valid. Clear has priority over a coincident in_valid; that sample is dropped. clear in IDLE is harmless.
- Arithmetic: unsigned, modulo 2^ACC_W (carry discarded) without the optional feature.
- busy = (state==ACCUM), registered.
- out_ovf without the optional feature: constant 0.

Optional Feature:
- Macro ACC_DUMP_SAT_EN.
- Defined:
  - Each addition saturates at 2^ACC_W-1.
  - Per-frame sticky overflow bit sets on any saturating add and clears at frame start and on clear.
  - out_ovf<=sticky (including the final add) together with out_valid and out_data.
- Undefined:
  - Wrap-around arithmetic; no sticky logic is synthesised.
  - out_ovf tied 0.

Test Plan:
1. Defaults, len=3, in_valid=1 with 10,20,30,40 on consecutive cycles -> acc_q 10,30,60 then 0; single out_valid pulse, out_data=100, one cycle after 40; busy low afterwards.
2. len=0, samples 5 then 7 back-to-back -> two consecutive out_valid pulses with out_data 5 then 7; acc_q stays 0.
3. len=2, samples 1,2,3 separated by 2-cycle in_valid=0 gaps; len changed to 9 after the first sample -> one pulse, out_data=6, 1 cycle after sample 3; no early pulse.
4. ACC_W=8, len=1, samples 200,100:
   - Macro undefined -> out_data=44, out_ovf=0.
   - ACC_DUMP_SAT_EN defined -> out_data=255, out_ovf=1.
   - Next frame 1,1 -> out_data=2, out_ovf=0.
5. len=3, samples 4,4 accepted, then clear=1 with in_valid=1 carrying 9 -> no pulse, acc_q=0. Following frame 1,1,1,1 -> out_data=4.
6. len=3, two samples accepted, rst_n pulsed low mid-cycle -> acc_q, out_data, out_valid, busy go to 0 immediately without a clock edge. After release, frame 2,2,2,2 -> out_data=8.

Source files
------------

// File: rtl/acc_dump.sv
// Integrate-and-dump accumulator: sums a programmable number of valid samples,
// emits the frame total with a one-cycle out_valid pulse, then restarts at zero.
// Optional saturating arithmetic with per-frame sticky overflow: ACC_DUMP_SAT_EN.
module acc_dump #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_q,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] acc_d;
  logic             out_valid_d;
  logic [ACC_W-1:0] out_data_d;
  logic             busy_d;

  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] sum;
  logic             accept;
  logic             last;

  assign in_ext = ACC_W'(in_data);
  assign accept = in_valid & ~clear;
  // Frame ends on this sample: immediately for len=0 in IDLE, else when cnt reaches len_q.
  assign last   = accept & ((state_q == StIdle) ? (len == '0) : (cnt_q == len_q));

`ifdef ACC_DUMP_SAT_EN
  logic [ACC_W:0] sum_full;
  logic           carry;
  logic           ovf_q, ovf_d;
  logic           out_ovf_d;

  assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};
  assign carry    = sum_full[ACC_W];
  assign sum      = carry ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];

  // Sticky overflow: acc_q and ovf_q are zero in IDLE, so a frame start clears it naturally.
  always_comb begin
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (accept) begin
      if (last) begin
        out_ovf_d = ovf_q | carry;
        ovf_d     = 1'b0;
      end else begin
        ovf_d = ovf_q | carry;
      end
    end
  end

  // Overflow state and registered overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q   <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      out_ovf <= out_ovf_d;
    end
  end
`else
  // Wrap-around: carry out of the top bit is discarded.
  assign sum     = acc_q + in_ext;
  assign out_ovf = 1'b0;
`endif

  // Next-state and output decode for the accumulate/dump FSM.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data;
    if (clear) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      if (state_q == StIdle) begin
        len_d = len;
      end
      if (last) begin
        // acc_q is zero in IDLE, so sum equals the lone sample for len=0.
        out_valid_d = 1'b1;
        out_data_d  = sum;
        acc_d       = '0;
        cnt_d       = '0;
        state_d     = StIdle;
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = StAccum;
      end
    end
    busy_d = (state_d == StAccum);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_acc_dump.sv
// Self-checking bench for acc_dump: a default-width instance and an 8-bit accumulator
// instance share one stimulus stream and are compared against a frame-level model.
module tb_acc_dump;

`ifdef ACC_DUMP_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [7:0]  len = '0;
  logic        clear = 1'b0;

  logic [15:0] a_acc, a_od;
  logic        a_ov, a_ovf, a_busy;
  logic [7:0]  b_acc, b_od;
  logic        b_ov, b_ovf, b_busy;

  acc_dump dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .len(len),
    .clear(clear), .acc_q(a_acc), .out_valid(a_ov), .out_data(a_od), .out_ovf(a_ovf),
    .busy(a_busy)
  );

  acc_dump #(.IN_W(8), .ACC_W(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .len(len),
    .clear(clear), .acc_q(b_acc), .out_valid(b_ov), .out_data(b_od), .out_ovf(b_ovf),
    .busy(b_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Frame-level model: samples of the open frame, its length, and last dump results.
  int unsigned m_q[$];
  int unsigned m_len = 0;
  bit          m_ov = 1'b0;
  longint      m_od16 = 0, m_od8 = 0;
  bit          m_of16 = 1'b0, m_of8 = 1'b0;

  function automatic longint fit(longint t, int unsigned w);
    longint mx = (longint'(1) << w) - 1;
    if (SatEn) return (t > mx) ? mx : t;
    return t & mx;
  endfunction

  function automatic bit over(longint t, int unsigned w);
    longint mx = (longint'(1) << w) - 1;
    return SatEn && (t > mx);
  endfunction

  function automatic longint qsum();
    longint s = 0;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_len = 0; m_ov = 1'b0;
    m_od16 = 0; m_od8 = 0; m_of16 = 1'b0; m_of8 = 1'b0;
  endtask

  task automatic m_step(input bit v, input int unsigned d, input int unsigned l, input bit c);
    longint tot;
    m_ov = 1'b0;
    if (c) begin
      m_q.delete();
    end else if (v) begin
      if (m_q.size() == 0) m_len = l;
      m_q.push_back(d);
      if (m_q.size() == m_len + 1) begin
        tot    = qsum();
        m_ov   = 1'b1;
        m_od16 = fit(tot, 16); m_of16 = over(tot, 16);
        m_od8  = fit(tot, 8);  m_of8  = over(tot, 8);
        m_q.delete();
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    longint s = qsum();
    bit     bz = (m_q.size() != 0);
    chk("a.acc_q", longint'(a_acc), bz ? fit(s, 16) : 0);
    chk("a.out_valid", longint'(a_ov), longint'(m_ov));
    chk("a.out_data", longint'(a_od), m_od16);
    chk("a.out_ovf", longint'(a_ovf), longint'(m_of16));
    chk("a.busy", longint'(a_busy), longint'(bz));
    chk("b.acc_q", longint'(b_acc), bz ? fit(s, 8) : 0);
    chk("b.out_valid", longint'(b_ov), longint'(m_ov));
    chk("b.out_data", longint'(b_od), m_od8);
    chk("b.out_ovf", longint'(b_ovf), longint'(m_of8));
    chk("b.busy", longint'(b_busy), longint'(bz));
  endtask

  // Drive one cycle of inputs, clock it, and compare both instances against the model.
  task automatic apply(input bit v, input logic [7:0] d, input logic [7:0] l, input bit c);
    in_valid = v; in_data = d; len = l; clear = c;
    @(posedge clk);
    m_step(v, d, l, c);
    #1;
    check_all();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [7:0] l;
    bit         c;
    int         exp_acc;
    bit         exp_ov;
    int         exp_od;
    bit         exp_busy;
  } vec_t;

  vec_t tab[5];

  initial begin
    // Basic 4-sample frame on the 16-bit instance.
    tab[0] = '{1'b1, 8'd10, 8'd3, 1'b0, 10,  1'b0, 0,   1'b1};
    tab[1] = '{1'b1, 8'd20, 8'd3, 1'b0, 30,  1'b0, 0,   1'b1};
    tab[2] = '{1'b1, 8'd30, 8'd3, 1'b0, 60,  1'b0, 0,   1'b1};
    tab[3] = '{1'b1, 8'd40, 8'd3, 1'b0, 0,   1'b1, 100, 1'b0};
    tab[4] = '{1'b0, 8'd0,  8'd3, 1'b0, 0,   1'b0, 100, 1'b0};

    #1 rst_n = 1'b0;
    m_reset();
    #3;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    for (int i = 0; i < 5; i++) begin
      apply(tab[i].v, tab[i].d, tab[i].l, tab[i].c);
      chk("t1.acc_q", longint'(a_acc), longint'(tab[i].exp_acc));
      chk("t1.out_valid", longint'(a_ov), longint'(tab[i].exp_ov));
      chk("t1.out_data", longint'(a_od), longint'(tab[i].exp_od));
      chk("t1.busy", longint'(a_busy), longint'(tab[i].exp_busy));
    end

    // len=0: each sample is its own frame, back-to-back pulses.
    apply(1'b1, 8'd5, 8'd0, 1'b0);
    chk("t2.pulse5", longint'({a_ov, a_od}), longint'({1'b1, 16'd5}));
    apply(1'b1, 8'd7, 8'd0, 1'b0);
    chk("t2.pulse7", longint'({a_ov, a_od}), longint'({1'b1, 16'd7}));
    chk("t2.acc_q", longint'(a_acc), 0);
    apply(1'b0, 8'd0, 8'd0, 1'b0);

    // Gapped samples; len change mid-frame is ignored.
    apply(1'b1, 8'd1, 8'd2, 1'b0);
    apply(1'b0, 8'd0, 8'd9, 1'b0);
    apply(1'b0, 8'd0, 8'd9, 1'b0);
    apply(1'b1, 8'd2, 8'd9, 1'b0);
    chk("t3.no_early", longint'(a_ov), 0);
    apply(1'b0, 8'd0, 8'd9, 1'b0);
    apply(1'b0, 8'd0, 8'd9, 1'b0);
    apply(1'b1, 8'd3, 8'd9, 1'b0);
    chk("t3.pulse", longint'({a_ov, a_od}), longint'({1'b1, 16'd6}));
    apply(1'b0, 8'd0, 8'd9, 1'b0);

    // 8-bit accumulator overflow, then a clean frame clears the flag.
    apply(1'b1, 8'd200, 8'd1, 1'b0);
    apply(1'b1, 8'd100, 8'd1, 1'b0);
    chk("t4.b_data", longint'(b_od), SatEn ? 255 : 44);
    chk("t4.b_ovf", longint'(b_ovf), longint'(SatEn));
    chk("t4.a_data", longint'(a_od), 300);
    apply(1'b1, 8'd1, 8'd1, 1'b0);
    apply(1'b1, 8'd1, 8'd1, 1'b0);
    chk("t4.b_next", longint'({b_ov, b_ovf, b_od}), longint'({1'b1, 1'b0, 8'd2}));

    // Clear beats a coincident sample.
    apply(1'b1, 8'd4, 8'd3, 1'b0);
    apply(1'b1, 8'd4, 8'd3, 1'b0);
    apply(1'b1, 8'd9, 8'd3, 1'b1);
    chk("t5.clear", longint'({a_ov, a_busy, a_acc}), 0);
    for (int i = 0; i < 4; i++) apply(1'b1, 8'd1, 8'd3, 1'b0);
    chk("t5.after", longint'({a_ov, a_od}), longint'({1'b1, 16'd4}));

    // Asynchronous reset mid-frame, between clock edges.
    apply(1'b1, 8'd3, 8'd3, 1'b0);
    apply(1'b1, 8'd3, 8'd3, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("t6.async", longint'({a_acc, a_od, a_ov, a_busy}), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) apply(1'b1, 8'd2, 8'd3, 1'b0);
    chk("t6.after", longint'({a_ov, a_od}), longint'({1'b1, 16'd8}));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] rl;
      rl = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      apply($urandom_range(0, 9) < 7, 8'($urandom), rl, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
